relu3_reader: RTL
=================

# relu3_reader

Read-side sequencer for the 64-entry ReLU3 activation buffer. On `start` it walks the buffer's read address from 0 to NUM_ENTRIES-1 and samples the buffer's combinational read data. It presents each entry, with its index, on a registered valid/ready stream to the next layer (final FC / classifier). When the last beat has been accepted it pulses `done`.

## Interface
Parameters:
- NUM_ENTRIES, 64: entries in the source buffer; also the sweep length.
- ADDR_WIDTH, 16: width of the buffer address and of `out_index`.
- DATA_WIDTH, 32: activation width, signed.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begins one sweep; sampled only in IDLE.
- mem_read_addr  out  ADDR_WIDTH  address driven to the buffer's read port.
- mem_read_data  in  DATA_WIDTH signed  buffer data for `mem_read_addr`, same cycle (combinational read).
- out_valid  out  1  `out_data`/`out_index`/`out_last` hold a beat.
- out_ready  in  1  consumer accepts the beat when `out_valid & out_ready`.
- out_data  out  DATA_WIDTH signed  activation value.
- out_index  out  ADDR_WIDTH  buffer address the value came from.
- out_last  out  1  beat is index NUM_ENTRIES-1.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on `start`; the address counter is cleared to 0. `start` in any other state is ignored.
- RUN:
  - Output register is "free" when `!out_valid` or `out_valid & out_ready`.
  - When free, the register loads `mem_read_data` with `out_index` = current address and sets `out_valid`. The address then increments.
  - If the loaded address is NUM_ENTRIES-1, `out_last` is set, the address holds, and the FSM goes to DRAIN.
  - When not free, the address and all outputs hold.
- DRAIN -> DONE when `out_valid & out_ready` with `out_last`. `out_valid` and `out_last` clear on that edge.
- DONE: `done`=1 for exactly one cycle, then IDLE. A new `start` is accepted from IDLE the following cycle.
- `mem_read_addr` equals the address counter. It is 0 in IDLE and never exceeds NUM_ENTRIES-1.
- Data is passed through unmodified; no sign extension or saturation.
- Stream rule: while `out_valid & !out_ready`, the values of `out_data`, `out_index` and `out_last` are stable.

## Timing
- Reset values: state IDLE, address 0, `out_valid`=0, `out_data`=0, `out_index`=0, `out_last`=0, `busy`=0, `done`=0.
- `start` high at edge N: RUN from N. Address 0 is on `mem_read_addr` in cycle N+1. First beat has `out_valid`=1 after edge N+1.
- Throughput: one beat per cycle while `out_ready` is held high.
- Full sweep with `out_ready`=1 throughout: `start` edge N, `done` high in cycle N+NUM_ENTRIES+2. There are 64 consecutive valid cycles.
- Back-pressure: address advance stalls in the same cycle that `out_ready`=0 with `out_valid`=1. No beat is dropped or duplicated.
- Reset mid-sweep: on the next edge all outputs return to reset values and the FSM goes to IDLE. `done` is not pulsed and no further beats are emitted.
- `reset` and `start` in the same cycle: reset wins.

## Configuration
- `RELU3_READER_ZERO_SKIP_EN` defined:
  - In RUN, an entry whose `mem_read_data` == 0 at an address below NUM_ENTRIES-1 is skipped. The address advances in that cycle without loading or disturbing the output register.
  - Index NUM_ENTRIES-1 is always emitted, even when zero, so `out_last` always occurs.
  - An all-zero buffer yields exactly one beat: index 63, data 0.
- Not defined: every entry is emitted, in order, exactly once.

## Test plan
- Buffer[i]=i-32 for i=0..63, `out_ready`=1, pulse `start` -> 64 beats with `out_index` 0..63 and `out_data` -32..31. `out_last` only on index 63; `done` once, 66 cycles after `start`.
- Same data, `out_ready` toggling 1,0,1,0 -> beat sequence identical to the previous test. Outputs stable during every ready=0 cycle; `done` after the 64th acceptance.
- `reset` asserted at beat index 20 with `out_ready`=1 -> next cycle `out_valid`=0, `busy`=0, `mem_read_addr`=0, and `done` never pulses. A fresh `start` restarts from index 0.
- `start` pulsed again at index 10 and again in DRAIN -> both ignored; exactly 64 beats and one `done`.
- With ZERO_SKIP_EN, buffer zero except [5]=7, [40]=-3 -> beats (5,7), (40,-3), (63,0). `out_last` on index 63.
- With ZERO_SKIP_EN, all-zero buffer -> single beat (63,0) with `out_last`=1, then `done`.

Source files
------------

// File: rtl/relu3_reader.sv
// Read-side sequencer: sweeps the ReLU3 activation buffer and streams each entry with its index.
// Optional build macro RELU3_READER_ZERO_SKIP_EN drops zero entries (the final entry is always sent).
module relu3_reader #(
    parameter int NUM_ENTRIES = 64,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic [ADDR_WIDTH-1:0]        mem_read_addr,
    input  logic signed [DATA_WIDTH-1:0] mem_read_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0]        out_index,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);

    // state | meaning
    // IDLE  | waiting for start, address parked at 0
    // RUN   | walking addresses, loading the output register when it is free
    // DRAIN | last beat loaded, waiting for it to be accepted
    // DONE  | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ENTRIES - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  out_free;
    logic                  skip;

    assign mem_read_addr = addr;
    assign out_free      = !out_valid || out_ready;

`ifdef RELU3_READER_ZERO_SKIP_EN
    assign skip = (mem_read_data == '0) && (addr != LAST_ADDR);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        addr  <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (skip) begin
                        // skipped entry advances the sweep but may still retire a pending beat
                        addr <= addr + 1'b1;
                        if (out_valid && out_ready) begin
                            out_valid <= 1'b0;
                        end
                    end else if (out_free) begin
                        out_valid <= 1'b1;
                        out_data  <= mem_read_data;
                        out_index <= addr;
                        if (addr == LAST_ADDR) begin
                            out_last <= 1'b1;
                            state    <= DRAIN;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        addr      <= '0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
